mips_instr_encoder: RTL and testbench



---
 rtl/mips_instr_encoder.sv | 121 ++++++++++++
 tb/tb_mips_instr_encoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_encoder.sv
// Streams symbolic MIPS instructions in, assembles 32-bit words and writes them
// to consecutive instruction-memory addresses starting at 0.
module mips_instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        mnem,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W:0] LP_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LP_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_we, r_done, r_error;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [ADDR_W:0]     r_count;
    logic [31:0]         w_word;
    logic                w_legal, w_accept, w_restart;
    logic [ADDR_W:0]     w_cnt_inc;

    always_comb begin
        w_word  = '0;
        w_legal = 1'b1;
        case (mnem)
            4'd0:    w_word = {6'h00, rs, rt, rd, 5'd0, 6'h20};
            4'd1:    w_word = {6'h00, rs, rt, rd, 5'd0, 6'h22};
            4'd2:    w_word = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
            4'd3:    w_word = {6'h00, rs, rt, rd, 5'd0, 6'h24};
            4'd4:    w_word = {6'h00, rs, rt, rd, 5'd0, 6'h25};
            4'd5:    w_word = {6'h08, rs, rt, imm};
            4'd6:    w_word = {6'h0D, rs, rt, imm};
            4'd7:    w_word = {6'h23, rs, rt, imm};
            4'd8:    w_word = {6'h2B, rs, rt, imm};
            4'd9:    w_word = {6'h04, rs, rt, imm};
            default: w_legal = 1'b0;
        endcase
    end

    assign in_ready  = (r_state == S_LOAD);
    assign w_accept  = in_valid & in_ready;
    assign w_restart = start & (r_state != S_LOAD);
    assign w_cnt_inc = r_count + LP_ONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Filling the last address ends the session even without in_last.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD: begin
                if (w_accept) begin
                    if (!w_legal)
                        w_state_nxt = S_ERR;
                    else if (in_last || (w_cnt_inc == LP_DEPTH))
                        w_state_nxt = S_DONE;
                end
            end
            default: begin
                if (start) w_state_nxt = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_restart) begin
                r_count <= '0;
                r_done  <= 1'b0;
                r_error <= 1'b0;
            end
            if (w_accept) begin
                if (w_legal) begin
                    r_we    <= 1'b1;
                    r_addr  <= r_count[ADDR_W-1:0];
                    r_wdata <= w_word;
                    r_count <= w_cnt_inc;
                    if (w_state_nxt == S_DONE) r_done <= 1'b1;
                end else begin
                    r_error <= 1'b1;
                end
            end
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign word_count = r_count;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Randomized + directed check of the instruction encoder against a per-cycle
// reference model; two instances (64-word and 4-word) share the same stimulus.
module tb_mips_instr_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [3:0]  mnem = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0;
    logic [15:0] imm = '0;

    logic        rdy_a, we_a, done_a, err_a;
    logic [5:0]  addr_a;
    logic [31:0] data_a;
    logic [6:0]  cnt_a;
    logic        rdy_b, we_b, done_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] data_b;
    logic [2:0]  cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    mips_instr_encoder #(.ADDR_W(6)) u_dut_a (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy_a),
        .in_last(in_last), .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(data_a),
        .word_count(cnt_a), .done(done_a), .error(err_a));

    mips_instr_encoder #(.ADDR_W(2)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy_b),
        .in_last(in_last), .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(data_b),
        .word_count(cnt_b), .done(done_b), .error(err_b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: one entry per instance.
    localparam logic [5:0] FN [5] = '{6'h20, 6'h22, 6'h2A, 6'h24, 6'h25};
    localparam logic [5:0] OP [5] = '{6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04};
    int          depth  [2] = '{64, 4};
    bit          m_load [2];
    bit          m_done [2];
    bit          m_err  [2];
    bit          m_we   [2];
    int          m_cnt  [2];
    int          m_addr [2];
    logic [31:0] m_data [2];

    function automatic logic [31:0] ref_word(input int m, input logic [4:0] s, input logic [4:0] t,
                                             input logic [4:0] d, input logic [15:0] i);
        if (m < 5) return {6'h00, s, t, d, 5'h00, FN[m]};
        return {OP[m-5], s, t, i};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_load[d] = 0; m_done[d] = 0; m_err[d] = 0; m_we[d] = 0;
            m_cnt[d] = 0; m_addr[d] = 0; m_data[d] = '0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_load[d] = 0; m_done[d] = 0; m_err[d] = 0; m_we[d] = 0;
                m_cnt[d] = 0; m_addr[d] = 0; m_data[d] = '0;
            end else begin
                m_we[d] = 0;
                if (m_load[d]) begin
                    if (in_valid) begin
                        if (int'(mnem) > 9) begin
                            m_err[d]  = 1;
                            m_load[d] = 0;
                        end else begin
                            m_we[d]   = 1;
                            m_addr[d] = m_cnt[d];
                            m_data[d] = ref_word(int'(mnem), rs, rt, rd, imm);
                            m_cnt[d]++;
                            if (in_last || m_cnt[d] == depth[d]) begin
                                m_done[d] = 1;
                                m_load[d] = 0;
                            end
                        end
                    end
                end else if (start) begin
                    m_load[d] = 1; m_cnt[d] = 0; m_done[d] = 0; m_err[d] = 0;
                end
            end
        end
    endtask

    task automatic chk_dut(input int d, input logic rdy, input logic we, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] cnt,
                           input logic dn, input logic er);
        chk($sformatf("d%0d_ready", d), {31'b0, rdy}, {31'b0, m_load[d]});
        chk($sformatf("d%0d_we", d),    {31'b0, we},  {31'b0, m_we[d]});
        chk($sformatf("d%0d_count", d), cnt, 32'(m_cnt[d]));
        chk($sformatf("d%0d_done", d),  {31'b0, dn},  {31'b0, m_done[d]});
        chk($sformatf("d%0d_error", d), {31'b0, er},  {31'b0, m_err[d]});
        if (m_we[d] || reset) begin
            chk($sformatf("d%0d_addr", d), addr, 32'(m_addr[d]));
            chk($sformatf("d%0d_wdata", d), data, m_data[d]);
        end
    endtask

    task automatic check_outs();
        chk_dut(0, rdy_a, we_a, {26'b0, addr_a}, data_a, {25'b0, cnt_a}, done_a, err_a);
        chk_dut(1, rdy_b, we_b, {30'b0, addr_b}, data_b, {29'b0, cnt_b}, done_b, err_b);
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_outs();
    endtask

    task automatic send(input logic [3:0] m, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [15:0] i, input logic last);
        in_valid = 1'b1; mnem = m; rs = s; rt = t; rd = d; imm = i; in_last = last;
        cyc();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; start = 1'b0; in_last = 1'b0;
        repeat (n) cyc();
    endtask

    // Reset takes effect immediately; check outputs before any clock edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_outs();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        check_outs();
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // single add with in_last
        pulse_start();
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1);
        chk("t1_word", data_a, 32'h00221820);
        chk("t1_addr", {26'b0, addr_a}, 32'd0);
        chk("t1_done", {31'b0, done_a}, 32'd1);
        chk("t1_count", {25'b0, cnt_a}, 32'd1);
        idle(2);

        // back-to-back lw / beq / ori
        pulse_start();
        send(4'd7, 5'd29, 5'd8, 5'd0, 16'h0004, 1'b0);
        chk("t2_lw", data_a, 32'h8FA80004);
        send(4'd9, 5'd1, 5'd2, 5'd0, 16'hFFFF, 1'b0);
        chk("t2_beq", data_a, 32'h1022FFFF);
        send(4'd6, 5'd0, 5'd5, 5'd0, 16'h00FF, 1'b1);
        chk("t2_ori", data_a, 32'h340500FF);
        chk("t2_addr", {26'b0, addr_a}, 32'd2);
        chk("t2_count", {25'b0, cnt_a}, 32'd3);
        idle(1);

        // all ten mnemonics with zero fields
        pulse_start();
        for (int m = 0; m < 10; m++) send(4'(m), 5'd0, 5'd0, 5'd0, 16'h0, m == 9);
        idle(1);

        // illegal third instruction, then recovery
        pulse_start();
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
        send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 1'b0);
        send(4'd12, 5'd7, 5'd8, 5'd9, 16'h0, 1'b0);
        chk("t4_we", {31'b0, we_a}, 32'd0);
        chk("t4_err", {31'b0, err_a}, 32'd1);
        chk("t4_done", {31'b0, done_a}, 32'd0);
        chk("t4_rdy", {31'b0, rdy_a}, 32'd0);
        idle(2);
        pulse_start();
        chk("t4_err_clr", {31'b0, err_a}, 32'd0);
        send(4'd4, 5'd1, 5'd1, 5'd1, 16'h0, 1'b1);
        chk("t4_addr0", {26'b0, addr_a}, 32'd0);
        idle(1);

        // fill the 4-word instance without in_last
        pulse_start();
        for (int k = 0; k < 5; k++) send(4'd0, 5'(k), 5'd2, 5'd3, 16'h0, 1'b0);
        chk("t5_cnt_b", {29'b0, cnt_b}, 32'd4);
        chk("t5_done_b", {31'b0, done_b}, 32'd1);
        chk("t5_rdy_b", {31'b0, rdy_b}, 32'd0);
        idle(1);

        // reset in the cycle after an accept drops the pending write
        pulse_start();
        in_valid = 1'b1; mnem = 4'd1; rs = 5'd3; rt = 5'd4; rd = 5'd5;
        model_edge();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        do_reset();
        idle(3);

        // randomized sessions
        for (int s = 0; s < 40; s++) begin
            pulse_start();
            repeat ($urandom_range(3, 14)) begin
                in_valid = ($urandom % 4) != 0;
                mnem     = ($urandom % 10 == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                rs       = 5'($urandom);
                rt       = 5'($urandom);
                rd       = 5'($urandom);
                imm      = 16'($urandom);
                in_last  = ($urandom % 8) == 0;
                start    = ($urandom % 10) == 0;
                cyc();
            end
            in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
            if (s % 7 == 3) do_reset();
            else            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
